tck7_udp_beacon: RTL and testbench



---
 rtl/tck7_udp_beacon.sv | 206 ++++++++++++++++++++
 tb/tb_tck7_udp_beacon.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tck7_udp_beacon.sv
// Free-running GMII beacon: one broadcast Ethernet/IPv4/UDP frame every PKT_DELAY_LIM cycles.
// Define TCK7_UDP_BEACON_RX_STATS_EN to report RX frame/error counts in payload bytes 4-11.
module tck7_udp_beacon #(
  parameter int unsigned PKT_DELAY_LIM = 125_000_000,
  parameter logic [47:0] SRC_MAC       = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC       = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP        = 32'hC0A8_0164,
  parameter logic [31:0] DST_IP        = 32'hFFFF_FFFF,
  parameter logic [15:0] UDP_SRC_PORT  = 16'd5000,
  parameter logic [15:0] UDP_DST_PORT  = 16'd5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [7:0] gmii_rxd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd
);

  localparam int unsigned PW = (PKT_DELAY_LIM > 1) ? $clog2(PKT_DELAY_LIM) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PKT_DELAY_LIM - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_HEADER   = 3'd2;
  localparam logic [2:0] S_PAYLOAD  = 3'd3;
  localparam logic [2:0] S_FCS      = 3'd4;

  function automatic logic [15:0] ip_csum(input logic [31:0] sip, input logic [31:0] dip);
    logic [31:0] s;
    s = 32'h0000_4500 + 32'h0000_00A8 + 32'h0000_4000 + 32'h0000_4011
      + {16'h0, sip[31:16]} + {16'h0, sip[15:0]} + {16'h0, dip[31:16]} + {16'h0, dip[15:0]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  localparam logic [15:0] IP_CSUM = ip_csum(SRC_IP, DST_IP);

  // Frame bytes 8-49, first byte in the top bits.
  localparam logic [335:0] HDR = {DST_MAC, SRC_MAC, 16'h0800,
                                  16'h4500, 16'h00A8, 16'h0000, 16'h4000, 16'h4011, IP_CSUM,
                                  SRC_IP, DST_IP,
                                  UDP_SRC_PORT, UDP_DST_PORT, 16'h0094, 16'h0000};

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  logic [PW-1:0] r_period;
  logic [2:0]    r_state;
  logic [7:0]    r_idx;
  logic [31:0]   r_crc;
  logic [31:0]   r_seq;
  logic          r_tx_en;
  logic [7:0]    r_txd;

  logic          w_wrap;
  logic          w_start;
  logic [7:0]    w_next_idx;
  logic [5:0]    w_hdr_off;
  logic [7:0]    w_pay_off;
  logic [1:0]    w_fcs_off;
  logic [335:0]  w_hdr_sh;
  logic [31:0]   w_fcs_sh;
  logic [7:0]    w_pay_byte;
  logic [7:0]    w_byte;
  logic          w_crc_en;

  assign w_wrap     = (r_period == PERIOD_LAST);
  assign w_start    = (r_state == S_IDLE) && w_wrap;
  assign w_next_idx = r_idx + 8'd1;
  assign w_pay_off  = w_next_idx - 8'd50;
  assign w_crc_en   = (w_next_idx >= 8'd8) && (w_next_idx < 8'd190);

`ifdef TCK7_UDP_BEACON_RX_STATS_EN
  logic        r_rx_dv_q;
  logic [31:0] r_rx_frames;
  logic [31:0] r_rx_errs;
  logic [31:0] r_snap_frames;
  logic [31:0] r_snap_errs;
  logic        w_unused;

  assign w_unused = ^gmii_rxd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_dv_q     <= 1'b0;
      r_rx_frames   <= 32'd0;
      r_rx_errs     <= 32'd0;
      r_snap_frames <= 32'd0;
      r_snap_errs   <= 32'd0;
    end else begin
      r_rx_dv_q <= gmii_rx_dv;
      if (gmii_rx_dv && !r_rx_dv_q && (r_rx_frames != 32'hFFFF_FFFF)) begin
        r_rx_frames <= r_rx_frames + 32'd1;
      end
      if (gmii_rx_dv && gmii_rx_er && (r_rx_errs != 32'hFFFF_FFFF)) begin
        r_rx_errs <= r_rx_errs + 32'd1;
      end
      if (w_start) begin
        r_snap_frames <= r_rx_frames;
        r_snap_errs   <= r_rx_errs;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{gmii_rx_dv, gmii_rx_er, gmii_rxd};
`endif

  always_comb begin
    w_pay_byte = w_pay_off;
    case (w_pay_off)
      8'd0:  w_pay_byte = r_seq[31:24];
      8'd1:  w_pay_byte = r_seq[23:16];
      8'd2:  w_pay_byte = r_seq[15:8];
      8'd3:  w_pay_byte = r_seq[7:0];
`ifdef TCK7_UDP_BEACON_RX_STATS_EN
      8'd4:  w_pay_byte = r_snap_frames[31:24];
      8'd5:  w_pay_byte = r_snap_frames[23:16];
      8'd6:  w_pay_byte = r_snap_frames[15:8];
      8'd7:  w_pay_byte = r_snap_frames[7:0];
      8'd8:  w_pay_byte = r_snap_errs[31:24];
      8'd9:  w_pay_byte = r_snap_errs[23:16];
      8'd10: w_pay_byte = r_snap_errs[15:8];
      8'd11: w_pay_byte = r_snap_errs[7:0];
`endif
      default: ;
    endcase
  end

  // Byte mux is driven by the index of the byte about to be loaded into r_txd.
  always_comb begin
    w_hdr_off = 6'(w_next_idx - 8'd8);
    w_fcs_off = 2'(w_next_idx - 8'd190);
    w_hdr_sh  = HDR << {w_hdr_off, 3'b000};
    w_fcs_sh  = (~r_crc) >> {w_fcs_off, 3'b000};
    w_byte    = 8'h00;
    if (w_next_idx < 8'd7) begin
      w_byte = 8'h55;
    end else if (w_next_idx == 8'd7) begin
      w_byte = 8'hD5;
    end else if (w_next_idx < 8'd50) begin
      w_byte = w_hdr_sh[335:328];
    end else if (w_next_idx < 8'd190) begin
      w_byte = w_pay_byte;
    end else begin
      w_byte = w_fcs_sh[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period <= '0;
      r_state  <= S_IDLE;
      r_idx    <= 8'd0;
      r_crc    <= 32'hFFFF_FFFF;
      r_seq    <= 32'd0;
      r_tx_en  <= 1'b0;
      r_txd    <= 8'h00;
    end else begin
      r_period <= w_wrap ? '0 : r_period + PW'(1);
      case (r_state)
        S_IDLE: begin
          if (w_wrap) begin
            r_state <= S_PREAMBLE;
            r_idx   <= 8'd0;
            r_tx_en <= 1'b1;
            r_txd   <= 8'h55;
            r_crc   <= 32'hFFFF_FFFF;
          end
        end
        default: begin
          if (r_idx == 8'd193) begin
            r_state <= S_IDLE;
            r_idx   <= 8'd0;
            r_tx_en <= 1'b0;
            r_txd   <= 8'h00;
            r_crc   <= 32'hFFFF_FFFF;
            r_seq   <= r_seq + 32'd1;
          end else begin
            r_idx <= w_next_idx;
            r_txd <= w_byte;
            if (w_crc_en) r_crc <= crc_byte(r_crc, w_byte);
            if (w_next_idx == 8'd8) r_state <= S_HEADER;
            else if (w_next_idx == 8'd50) r_state <= S_PAYLOAD;
            else if (w_next_idx == 8'd190) r_state <= S_FCS;
          end
        end
      endcase
    end
  end

  assign gmii_tx_en = r_tx_en;
  assign gmii_txd   = r_txd;
  assign gmii_tx_er = 1'b0;

endmodule

// File: tb/tb_tck7_udp_beacon.sv
// Scoreboard bench for tck7_udp_beacon: expected frames/start cycles are queued by the
// stimulus; a monitor pops and compares every transmitted byte and frame start.
`timescale 1ns/1ps
module tb_tck7_udp_beacon;

  localparam int unsigned LIM = 1250;
`ifdef TCK7_UDP_BEACON_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_dv = 1'b0;
  logic       rx_er = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic       tx_en;
  logic       tx_er;
  logic [7:0] txd;

  tck7_udp_beacon #(.PKT_DELAY_LIM(LIM)) dut (
    .clk        (clk),
    .reset      (reset),
    .gmii_rx_dv (rx_dv),
    .gmii_rx_er (rx_er),
    .gmii_rxd   (rxd),
    .gmii_tx_en (tx_en),
    .gmii_tx_er (tx_er),
    .gmii_txd   (txd)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int rise_q[$];

  // Hand-assembled bytes 0-49; IPv4 checksum 0x7839 worked out by hand for the defaults.
  logic [7:0] hdr_ref [50] = '{
    8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
    8'h08, 8'h00,
    8'h45, 8'h00, 8'h00, 8'hA8, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11, 8'h78, 8'h39,
    8'hC0, 8'hA8, 8'h01, 8'h64, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h13, 8'h88, 8'h13, 8'h88, 8'h00, 8'h94, 8'h00, 8'h00
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Bit-serial reflected CRC-32.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  task automatic push_frame(input logic [31:0] seq, input logic [31:0] rxf,
                            input logic [31:0] rxe);
    logic [7:0]  f [194];
    logic [31:0] c;
    for (int i = 0; i < 50; i++) f[i] = hdr_ref[i];
    for (int p = 0; p < 140; p++) f[50 + p] = 8'(p);
    f[50] = seq[31:24]; f[51] = seq[23:16]; f[52] = seq[15:8]; f[53] = seq[7:0];
    if (STATS) begin
      f[54] = rxf[31:24]; f[55] = rxf[23:16]; f[56] = rxf[15:8]; f[57] = rxf[7:0];
      f[58] = rxe[31:24]; f[59] = rxe[23:16]; f[60] = rxe[15:8]; f[61] = rxe[7:0];
    end
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 190; i++) c = crc_upd(c, f[i]);
    c = ~c;
    f[190] = c[7:0]; f[191] = c[15:8]; f[192] = c[23:16]; f[193] = c[31:24];
    for (int i = 0; i < 194; i++) exp_q.push_back(f[i]);
  endtask

  initial begin : monitor
    logic        prev_en;
    int          nbytes;
    logic [7:0]  cap [194];
    logic [31:0] c;
    prev_en = 1'b0;
    nbytes  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        cyc     = 0;
        prev_en = 1'b0;
        nbytes  = 0;
        exp_q.delete();
        rise_q.delete();
      end else begin
        cyc++;
        if (tx_en) begin
          if (!prev_en) begin
            chk("rise_pending", 32'(rise_q.size() > 0), 32'd1);
            if (rise_q.size() > 0) chk("rise_cycle", 32'(cyc), 32'(rise_q.pop_front()));
          end
          chk("byte_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("txd_byte", {24'h0, txd}, {24'h0, exp_q.pop_front()});
          if (nbytes < 194) cap[nbytes] = txd;
          nbytes++;
        end else if (prev_en) begin
          chk("frame_len", 32'(nbytes), 32'd194);
          chk("idle_txd", {24'h0, txd}, 32'd0);
          chk("tx_er", {31'h0, tx_er}, 32'd0);
          if (nbytes == 194) begin
            c = 32'hFFFF_FFFF;
            for (int i = 8; i < 194; i++) c = crc_upd(c, cap[i]);
            chk("fcs_residue", c, 32'hDEBB_20E3);
          end
          nbytes = 0;
        end
        prev_en = tx_en;
      end
    end
  end

  initial begin : stim
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx_en", {31'h0, tx_en}, 32'd0);
    chk("rst_txd", {24'h0, txd}, 32'd0);
    chk("rst_tx_er", {31'h0, tx_er}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 5; s++) begin
      push_frame(32'(s), 32'd0, 32'd0);
      rise_q.push_back(int'(LIM) * (s + 1));
    end
    // Fifth frame starts at cycle 5*LIM; stop it while byte 100 is on the wire.
    repeat (5 * LIM + 100) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_tx_en", {31'h0, tx_en}, 32'd0);
    chk("midreset_txd", {24'h0, txd}, 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    push_frame(32'd0, 32'd5, 32'd2);
    push_frame(32'd1, 32'd5, 32'd2);
    rise_q.push_back(int'(LIM));
    rise_q.push_back(2 * int'(LIM));
    repeat (20) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      rx_dv = 1'b1;
      for (int j = 0; j < 10; j++) begin
        rx_er = ((k % 2) == 1) && (j == 4);
        rxd   = 8'(k * 16 + j);
        @(negedge clk);
      end
      rx_dv = 1'b0;
      rx_er = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (2 * LIM + 214 - 95) @(negedge clk);
    chk("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    chk("rises_outstanding", 32'(rise_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
